// File: rtl/ecc_scrub_ctrl_if.sv
// rtl/ecc_scrub_ctrl_if.sv - scrub write-back port between scrub controller and memory
interface ecc_scrub_ctrl_if #(
    parameter int AW = 16
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [38:0]   wr_data;
    logic          wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - SEC scrub write-back, saturating SEC/DED statistics, error log and DED interrupt
module ecc_scrub_ctrl #(
    parameter int AW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scrub_en,
    input  logic          rd_valid,
    input  logic [AW-1:0] rd_addr,
    input  logic [31:0]   dec_dout,
    input  logic [6:0]    dec_ecc_out,
    input  logic          single_ecc_error,
    input  logic          double_ecc_error,
    input  logic          clr_stats,
    ecc_scrub_ctrl_if.master wr,
    output logic [CW-1:0] sec_count,
    output logic [CW-1:0] ded_count,
    output logic [CW-1:0] drop_count,
    output logic          log_valid,
    output logic [AW-1:0] log_addr,
    output logic          log_ded,
    output logic          ded_irq
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t        state_q;
    logic          wr_req_q;
    logic [AW-1:0] wr_addr_q;
    logic [38:0]   wr_data_q;
    logic [CW-1:0] sec_cnt_q, ded_cnt_q, drop_cnt_q;
    logic [CW-1:0] sec_cnt_d, ded_cnt_d, drop_cnt_d;
    logic          log_valid_q, log_ded_q, ded_irq_q;
    logic [AW-1:0] log_addr_q;

    logic ded_ev, sec_ev, scrub_ev, hs, drop_ev;

    assign ded_ev   = rd_valid & double_ecc_error;
    assign sec_ev   = rd_valid & single_ecc_error & ~double_ecc_error;
    assign scrub_ev = sec_ev & scrub_en;
    assign hs       = (state_q == REQ) & wr.wr_ack;
    assign drop_ev  = scrub_ev & (state_q == REQ) & ~wr.wr_ack;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Clear takes effect first so a coincident event lands on a zeroed counter.
    always_comb begin
        sec_cnt_d  = clr_stats ? '0 : sec_cnt_q;
        ded_cnt_d  = clr_stats ? '0 : ded_cnt_q;
        drop_cnt_d = clr_stats ? '0 : drop_cnt_q;
        if (sec_ev)  sec_cnt_d  = sat_inc(sec_cnt_d);
        if (ded_ev)  ded_cnt_d  = sat_inc(ded_cnt_d);
        if (drop_ev) drop_cnt_d = sat_inc(drop_cnt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scrub_ev) begin
                        state_q   <= REQ;
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= rd_addr;
                        wr_data_q <= {dec_ecc_out, dec_dout};
                    end
                end
                REQ: begin
                    // A SEC arriving on the handshake cycle chains straight into the next write.
                    if (hs) begin
                        if (scrub_ev) begin
                            wr_addr_q <= rd_addr;
                            wr_data_q <= {dec_ecc_out, dec_dout};
                        end else begin
                            state_q  <= IDLE;
                            wr_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_ded_q   <= 1'b0;
            ded_irq_q   <= 1'b0;
        end else begin
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ded_irq_q  <= ded_ev;
            if (sec_ev || ded_ev) begin
                log_valid_q <= 1'b1;
                log_addr_q  <= rd_addr;
                log_ded_q   <= ded_ev;
            end else if (clr_stats) begin
                log_valid_q <= 1'b0;
                log_addr_q  <= '0;
                log_ded_q   <= 1'b0;
            end
        end
    end

    assign wr.wr_req   = wr_req_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign sec_count   = sec_cnt_q;
    assign ded_count   = ded_cnt_q;
    assign drop_count  = drop_cnt_q;
    assign log_valid   = log_valid_q;
    assign log_addr    = log_addr_q;
    assign log_ded     = log_ded_q;
    assign ded_irq     = ded_irq_q;
endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
- Sits directly downstream of rvecc_decode on the memory read path.
- Consumes the decoder's corrected data/check bits and its single_ecc_error/double_ecc_error flags. Issues a scrub write-back of the corrected 39-bit codeword to the faulting address over a req/ack write port.
- Maintains saturating SEC/DED statistics and a sticky last-error log. Pulses an interrupt on uncorrectable (DED) errors.

Parameters:
AW, 16, read/scrub address width
CW, 16, width of each statistics counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
scrub_en  input  1  1 = write back corrected codeword on SEC; 0 = count/log only
rd_valid  input  1  decoder outputs valid this cycle
rd_addr  input  AW  address of the word being decoded
dec_dout  input  32  corrected data from decoder
dec_ecc_out  input  7  corrected check bits from decoder
single_ecc_error  input  1  decoder SEC flag
double_ecc_error  input  1  decoder DED flag
wr_ack  input  1  memory accepts scrub write this cycle
clr_stats  input  1  single-cycle clear of counters, log and overflow
wr_req  output  1  scrub write request
wr_addr  output  AW  scrub address
wr_data  output  39  {ecc, data} codeword to write
sec_count  output  CW  saturating count of SEC events
ded_count  output  CW  saturating count of DED events
drop_count  output  CW  saturating count of SEC scrubs dropped while busy
log_valid  output  1  sticky: an error has been logged since reset/clear
log_addr  output  AW  address of most recent error
log_ded  output  1  1 = most recent error was DED
ded_irq  output  1  one-cycle pulse per DED event

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; wr_req=0, wr_addr=0, wr_data=0, all counters 0, log_valid=0, log_addr=0, log_ded=0, ded_irq=0. Reset mid-scrub abandons the pending write; wr_req is low the cycle after reset.
- Event decode applies only when rd_valid=1:
  - DED = double_ecc_error.
  - SEC = single_ecc_error & ~double_ecc_error. DED has priority if both flags are set.
  - With rd_valid=0, both flags are ignored.
- Statistics, registered one cycle after the event:
  - SEC increments sec_count; DED increments ded_count.
  - All counters saturate at 2^CW-1 with no wrap.
- Log: on any SEC/DED event, log_addr<=rd_addr, log_ded<=DED, log_valid<=1. The most recent event overwrites the log.
- ded_irq: high exactly in cycle N+1 for a DED at cycle N. Back-to-back DEDs give a high pulse on consecutive cycles.
- clr_stats: zeroes the counters, log_valid, log_addr and log_ded. If an event coincides with clr_stats, the clear applies first and the event is then recorded (counter=1, log holds the new event). clr_stats does not affect the scrub FSM.
- DED never triggers a scrub write, because the data is not recoverable.
- Scrub FSM has two states, IDLE and REQ:
  - IDLE: an SEC with scrub_en=1 at cycle N loads wr_addr<=rd_addr and wr_data<={dec_ecc_out, dec_dout}, then goes to REQ. wr_req=1 from cycle N+1.
  - REQ: wr_req=1; wr_addr and wr_data are held stable until the handshake. The handshake completes on the cycle where wr_req & wr_ack.
  - On handshake with no new SEC in that cycle: go to IDLE, wr_req=0 next cycle.
  - On handshake with a new scrubbable SEC in the same cycle: load the new address/data and stay in REQ (back-to-back; no idle bubble).
  - In REQ without handshake, a new scrubbable SEC is dropped and drop_count increments (saturating). The SEC is still counted in sec_count and logged.
  - scrub_en only gates new acceptance; deasserting it while in REQ does not cancel the outstanding write.
- wr_ack while in IDLE is ignored.
- Latency: SEC to wr_req = 1 cycle; SEC to counter/log update = 1 cycle.

Test Plan:
- After reset, rd_valid=1, single=1, rd_addr=0x0012, dout=0xDEADBEEF, ecc=0x55, scrub_en=1, wr_ack tied 1 -> next cycle wr_req=1, wr_addr=0x0012, wr_data=0x55DEADBEEF, sec_count=1, log_ded=0; the cycle after that wr_req=0.
- DED at rd_addr=0x0100 -> ded_count=1, ded_irq high one cycle, log_addr=0x0100, log_ded=1, wr_req stays 0.
- wr_ack=0; SEC at 0x0001, then SEC at 0x0002 two cycles later -> wr_addr stays 0x0001, drop_count=1, sec_count=2, log_addr=0x0002. Raising wr_ack completes the write and FSM returns to IDLE.
- SEC at 0x0003 held in REQ; new SEC at 0x0004 arrives in the same cycle as wr_ack -> next cycle wr_req=1, wr_addr=0x0004, drop_count unchanged.
- CW=4: 17 SEC events -> sec_count=15. clr_stats coincident with an SEC -> sec_count=1, log_valid=1.
- Assert rst while wr_req=1 -> next cycle wr_req=0, all counters 0, log_valid=0. Both flags set with rd_valid=0 -> no change.
